significand_rounder: RTL and testbench



---
 rtl/significand_rounder_pkg.sv | 20 ++
 rtl/significand_rounder_if.sv | 25 ++
 rtl/significand_rounder_round_decide.sv | 27 ++
 rtl/significand_rounder.sv | 69 ++++++
 tb/tb_significand_rounder.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/significand_rounder_pkg.sv
// Shared FPU rounding definitions: rounding-mode encoding and significand widths.
package significand_rounder_pkg;

  // Rounding mode encoding carried on the RM field.
  typedef enum logic [1:0] {
    RM_RZ  = 2'b00,
    RM_RNE = 2'b01,
    RM_RU  = 2'b10,
    RM_RD  = 2'b11
  } rm_e;

  localparam int unsigned SIG_D_W   = 53;                   // double significand
  localparam int unsigned SIG_S_W   = 24;                   // single significand
  localparam int unsigned F1_W      = 55;                   // significand + round + sticky
  localparam int unsigned F2_W      = 54;                   // carry-out + significand
  localparam int unsigned SUM_S_W   = SIG_S_W + 1;          // single sum incl. carry-out
  localparam int unsigned SGL_PAD_W = F2_W - SUM_S_W;       // zero fill below single result
  localparam int unsigned SGL_LSB   = F1_W - SIG_S_W;       // position of single L bit in f1

endpackage

// File: rtl/significand_rounder_if.sv
// Bus between the normalizer and the significand rounder.
//   master: drives in_valid/s/db/f1/RM, receives out_valid/f2/siginx
//   slave : the rounder itself
interface significand_rounder_if;
  import significand_rounder_pkg::*;

  logic              in_valid;
  logic              s;
  logic              db;
  logic [F1_W-1:0]   f1;
  logic [1:0]        RM;
  logic              out_valid;
  logic [F2_W-1:0]   f2;
  logic              siginx;

  modport master (
    output in_valid, s, db, f1, RM,
    input  out_valid, f2, siginx
  );

  modport slave (
    input  in_valid, s, db, f1, RM,
    output out_valid, f2, siginx
  );
endinterface

// File: rtl/significand_rounder_round_decide.sv
// Round-increment decision shared by the significand and exponent rounding paths.
//   s     : sign of the result (1 = negative)
//   rm    : rounding mode
//   l/r/st: least-significant kept bit, round bit, sticky bit
//   inc_c : add one ulp to the truncated significand (combinational)
module significand_rounder_round_decide
  import significand_rounder_pkg::*;
(
  input  logic s,
  input  rm_e  rm,
  input  logic l,
  input  logic r,
  input  logic st,
  output logic inc_c
);

  always_comb begin
    inc_c = 1'b0;
    unique case (rm)
      RM_RZ:  inc_c = 1'b0;
      RM_RNE: inc_c = r & (l | st);        // ties go to the even neighbour
      RM_RU:  inc_c = ~s & (r | st);
      RM_RD:  inc_c = s & (r | st);
    endcase
  end

endmodule

// File: rtl/significand_rounder.sv
// Registered significand rounding stage (sigrnd): rounds a normalized
// double or single significand, producing carry-out and an inexact flag.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : slave side of significand_rounder_if (inputs sampled when in_valid,
//         results appear one cycle later with out_valid)
module significand_rounder
  import significand_rounder_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  significand_rounder_if.slave bus
);

  logic [SIG_D_W-1:0] sig_d;
  logic [SIG_S_W-1:0] sig_s;
  logic               lsb_c;
  logic               rnd_c;
  logic               stk_c;
  logic               inc_c;
  logic [F2_W-1:0]    sum_d;
  logic [SUM_S_W-1:0] sum_s;
  logic [F2_W-1:0]    f2_c;

  // Split f1 into kept significand and round/sticky for each precision.
  assign sig_d = bus.f1[F1_W-1:2];
  assign sig_s = bus.f1[F1_W-1:SGL_LSB];

  always_comb begin
    lsb_c = bus.f1[SGL_LSB];
    rnd_c = bus.f1[SGL_LSB-1];
    stk_c = |bus.f1[SGL_LSB-2:0];
    if (bus.db) begin
      lsb_c = bus.f1[2];
      rnd_c = bus.f1[1];
      stk_c = bus.f1[0];
    end
  end

  significand_rounder_round_decide u_round_decide (
    .s     (bus.s),
    .rm    (rm_e'(bus.RM)),
    .l     (lsb_c),
    .r     (rnd_c),
    .st    (stk_c),
    .inc_c (inc_c)
  );

  // Increment with carry-out kept; an all-ones significand wraps to 1.000..0.
  assign sum_d = {1'b0, sig_d} + F2_W'(inc_c);
  assign sum_s = {1'b0, sig_s} + SUM_S_W'(inc_c);
  assign f2_c  = bus.db ? sum_d : {sum_s, {SGL_PAD_W{1'b0}}};

  // Single output register bank; f2/siginx hold while no input is valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.f2        <= '0;
      bus.siginx    <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.f2     <= f2_c;
        bus.siginx <= rnd_c | stk_c;
      end
    end
  end

endmodule

// File: tb/tb_significand_rounder.sv
// Self-checking bench for significand_rounder: directed cases plus a
// randomized sweep, expected results queued at drive time and popped at output.
module tb_significand_rounder;
  import significand_rounder_pkg::*;

  typedef struct packed {
    logic [F2_W-1:0] f2;
    logic            inx;
  } exp_t;

  logic clk;
  logic rst;
  significand_rounder_if bus ();

  significand_rounder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t        sb_q[$];
  int          errors = 0;
  int          checks = 0;
  exp_t        exp_v;
  logic [F1_W-1:0] rf1;
  logic        rs;
  logic        rdb;
  logic [1:0]  rrm;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference rounding written from the bit-level definition.
  function automatic exp_t model(input logic s, input logic db, input logic [1:0] rm,
                                 input logic [F1_W-1:0] f1);
    exp_t  e;
    logic  l, r, st, inc;
    logic [63:0] sig;
    if (db) begin
      sig = 64'(f1 >> 2);
      l = f1[2]; r = f1[1]; st = f1[0];
    end else begin
      sig = 64'(f1 >> 31);
      l = f1[31]; r = f1[30]; st = (f1 & 55'h3FFFFFFF) != 0;
    end
    case (rm)
      2'b00:   inc = 1'b0;
      2'b01:   inc = r && (l || st);
      2'b10:   inc = !s && (r || st);
      default: inc = s && (r || st);
    endcase
    sig = sig + 64'(inc);
    e.f2  = db ? F2_W'(sig) : F2_W'(sig << 29);
    e.inx = r | st;
    return e;
  endfunction

  // Drive one transaction, then compare the popped expectation one cycle later.
  task automatic apply(input string tag, input logic s, input logic db, input logic [1:0] rm,
                       input logic [F1_W-1:0] f1, input logic [F2_W-1:0] ef2, input logic einx);
    exp_t e;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.s = s; bus.db = db; bus.RM = rm; bus.f1 = f1;
    e.f2 = ef2; e.inx = einx;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    if (sb_q.size() == 0) begin
      check({tag, "_queue"}, 64'd0, 64'd1);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_f2"}, 64'(bus.f2), 64'(e.f2));
      check({tag, "_inx"}, 64'(bus.siginx), 64'(e.inx));
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.s = 1'b0; bus.db = 1'b1; bus.RM = 2'b01; bus.f1 = 55'h7FFFFFFFFFFFFF;

    // Reset has priority over in_valid.
    @(posedge clk); #1;
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_f2", 64'(bus.f2), 64'd0);
    check("rst_inx", 64'(bus.siginx), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;

    // Directed cases, back to back.
    apply("d_rne",     1'b0, 1'b1, RM_RNE, 55'h123456789ABCDE, 54'h048D159E26AF38, 1'b1);
    apply("d_carry",   1'b0, 1'b1, RM_RNE, 55'h7FFFFFFFFFFFFF, 54'h20000000000000, 1'b1);
    apply("d_exact",   1'b0, 1'b1, RM_RZ,  55'h40000000000000, 54'h10000000000000, 1'b0);
    apply("d_ru_neg",  1'b1, 1'b1, RM_RU,  55'h40000000000001, 54'h10000000000000, 1'b1);
    apply("d_rd_neg",  1'b1, 1'b1, RM_RD,  55'h40000000000001, 54'h10000000000001, 1'b1);
    apply("d_rz_inx",  1'b0, 1'b1, RM_RZ,  55'h7FFFFFFFFFFFFF, 54'h1FFFFFFFFFFFFF, 1'b1);
    apply("s_exact",   1'b0, 1'b0, RM_RNE, 55'h40000080000000, 54'h10000020000000, 1'b0);
    apply("s_tie",     1'b0, 1'b0, RM_RNE, 55'h40000040000000, 54'h10000000000000, 1'b1);
    apply("s_tie_ru",  1'b0, 1'b0, RM_RU,  55'h40000040000000, 54'h10000020000000, 1'b1);
    apply("s_tie_odd", 1'b0, 1'b0, RM_RNE, 55'h400000C0000000, 54'h10000040000000, 1'b1);
    apply("s_stk_rd",  1'b1, 1'b0, RM_RD,  55'h40000000000001, 54'h10000020000000, 1'b1);
    apply("s_carry",   1'b0, 1'b0, RM_RU,  55'h7FFFFFFFFFFFFF, 54'h20000000000000, 1'b1);

    // One-cycle pulse: out_valid drops, f2/siginx hold.
    apply("pulse", 1'b0, 1'b1, RM_RZ, 55'h40000000000000, 54'h10000000000000, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.f1 = 55'h123456789ABCDE;
    bus.RM = RM_RNE;
    @(posedge clk); #1;
    check("idle_valid", 64'(bus.out_valid), 64'd0);
    check("idle_f2", 64'(bus.f2), 64'h10000000000000);
    check("idle_inx", 64'(bus.siginx), 64'd0);
    @(posedge clk); #1;
    check("idle2_valid", 64'(bus.out_valid), 64'd0);
    check("idle2_f2", 64'(bus.f2), 64'h10000000000000);

    // Randomized sweep against the reference model.
    for (int i = 0; i < 40; i++) begin
      rf1 = F1_W'({$urandom(), $urandom()});
      rf1[F1_W-1] = 1'b1;
      if (i % 8 == 0) rf1[29:0] = '0;
      if (i % 5 == 0) rf1[1:0] = 2'b10;
      rs  = 1'($urandom_range(0, 1));
      rdb = 1'($urandom_range(0, 1));
      rrm = 2'($urandom_range(0, 3));
      exp_v = model(rs, rdb, rrm, rf1);
      apply("rand", rs, rdb, rrm, rf1, exp_v.f2, exp_v.inx);
    end

    // Reset mid-stream clears outputs.
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    check("rst2_valid", 64'(bus.out_valid), 64'd0);
    check("rst2_f2", 64'(bus.f2), 64'd0);
    check("rst2_inx", 64'(bus.siginx), 64'd0);
    check("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
